// File: rtl/psoc_audio_pkg.sv
// Shared register map, bit indices and types for the audio subsystem blocks.
// Offsets and bit positions are mirrored by the firmware headers.
package psoc_audio_pkg;

    localparam int unsigned HALF_W = 16;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int unsigned ST_EMPTY = 8;
    localparam int unsigned ST_FULL  = 9;
    localparam int unsigned ST_OVF   = 10;
    localparam int unsigned ST_HIGH  = 11;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_OVF_CLR = 1;
    localparam int unsigned CTRL_FLUSH   = 2;

    typedef struct packed {
        logic [HALF_W-1:0] left;
        logic [HALF_W-1:0] right;
    } i2s_frame_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_WAIT_SYNC,
        RX_LEFT,
        RX_RIGHT
    } rx_state_t;

    // Move a right-justified word of 'width' bits to the MSBs of a half-frame
    function automatic logic [HALF_W-1:0] align_word(input logic [HALF_W-1:0] w,
                                                     input int unsigned width);
        return w << (HALF_W - width);
    endfunction

endpackage

// File: rtl/psoc_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and a flush that wins over push/pop.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module psoc_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push_c;
    logic              do_pop_c;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);
    assign head      = mem[rd_ptr];

    // Storage needs no reset: the count defines which entries are live
    always_ff @(posedge clk) begin
        if (do_push_c && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psoc_i2s_rx.sv
// I2S slave receiver: oversampled pad inputs, L/R deserialiser, stereo frame FIFO
// read over Wishbone, and a level interrupt when the FIFO fill reaches a threshold.
module psoc_i2s_rx
    import psoc_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned FIFO_HIGH_LEVEL = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        fifo_high,
    input  logic        i2s_sclk,
    input  logic        i2s_lrclk,
    input  logic        i2s_sdata
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BIT_W = $clog2(SAMPLE_WIDTH + 2);
    localparam logic [BIT_W-1:0] BIT_DONE = BIT_W'(SAMPLE_WIDTH + 1);

    logic [1:0]              sclk_sync, lrclk_sync, sdata_sync;
    logic                    sclk_d, lr_prev;
    logic                    smp_c, lr_c, lr_fall_c, lr_rise_c;
    logic [BIT_W-1:0]        bit_cnt, bit_idx_c;
    logic                    word_ok_c;
    logic [SAMPLE_WIDTH-1:0] shift_q, left_q;
    logic                    frame_bad;
    rx_state_t               state, state_nxt;
    logic                    latch_left_c, mark_bad_c, new_frame_c, push_c;
    i2s_frame_t              frame_c;
    logic                    en, ovf;
    logic                    acc_c, wr_ctrl_c, pop_c, flush_c, ovf_set_c;
    logic [31:0]             rdata_c;
    logic [31:0]             fifo_head;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full, fifo_empty;
    logic                    unused_wb;

    assign unused_wb = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:3]};

    // Two-flop synchronisers plus a delayed sclk copy for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sclk_sync  <= '0;
            lrclk_sync <= '0;
            sdata_sync <= '0;
            sclk_d     <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[0], i2s_sclk};
            lrclk_sync <= {lrclk_sync[0], i2s_lrclk};
            sdata_sync <= {sdata_sync[0], i2s_sdata};
            sclk_d     <= sclk_sync[1];
        end
    end

    assign smp_c     = sclk_sync[1] & ~sclk_d;
    assign lr_c      = lrclk_sync[1];
    assign lr_fall_c = smp_c & lr_prev & ~lr_c;
    assign lr_rise_c = smp_c & ~lr_prev & lr_c;
    assign bit_idx_c = (lr_c != lr_prev) ? '0 : bit_cnt;
    // bit_cnt still describes the word that the current lrclk change terminates
    assign word_ok_c = (bit_cnt == BIT_DONE);

    // Index 0 is the I2S delay bit; indices past SAMPLE_WIDTH saturate and are dropped
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lr_prev <= 1'b0;
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (smp_c) begin
            lr_prev <= lr_c;
            bit_cnt <= (bit_idx_c == BIT_DONE) ? BIT_DONE : bit_idx_c + BIT_W'(1);
            if (bit_idx_c != '0 && bit_idx_c != BIT_DONE) begin
                shift_q <= {shift_q[SAMPLE_WIDTH-2:0], sdata_sync[1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        latch_left_c = 1'b0;
        mark_bad_c   = 1'b0;
        new_frame_c  = 1'b0;
        push_c       = 1'b0;
        if (!en) begin
            state_nxt = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: state_nxt = RX_WAIT_SYNC;
                RX_WAIT_SYNC: begin
                    if (lr_fall_c) begin
                        state_nxt   = RX_LEFT;
                        new_frame_c = 1'b1;
                    end
                end
                RX_LEFT: begin
                    if (lr_rise_c) begin
                        state_nxt    = RX_RIGHT;
                        latch_left_c = word_ok_c;
                        mark_bad_c   = ~word_ok_c;
                    end
                end
                RX_RIGHT: begin
                    if (lr_fall_c) begin
                        state_nxt   = RX_LEFT;
                        new_frame_c = 1'b1;
                        push_c      = word_ok_c & ~frame_bad;
                    end
                end
                default: state_nxt = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_bad <= 1'b0;
            left_q    <= '0;
        end else begin
            if (new_frame_c) begin
                frame_bad <= 1'b0;
            end else if (mark_bad_c) begin
                frame_bad <= 1'b1;
            end
            if (latch_left_c) begin
                left_q <= shift_q;
            end
        end
    end

    assign frame_c.left  = align_word(HALF_W'(left_q), SAMPLE_WIDTH);
    assign frame_c.right = align_word(HALF_W'(shift_q), SAMPLE_WIDTH);

    // Access qualifier is high only in the cycle that raises ack
    assign acc_c     = wb_stb_i & ~wb_ack_o;
    assign wr_ctrl_c = acc_c & wb_we_i & (wb_adr_i[3:2] == REG_CTRL);
    assign pop_c     = acc_c & ~wb_we_i & (wb_adr_i[3:2] == REG_DATA) & ~fifo_empty;
    assign flush_c   = wr_ctrl_c & wb_dat_i[CTRL_FLUSH];
    assign ovf_set_c = push_c & fifo_full & ~pop_c;

    always_comb begin
        rdata_c = '0;
        case (wb_adr_i[3:2])
            REG_DATA: begin
                if (!fifo_empty) begin
                    rdata_c = fifo_head;
                end
            end
            REG_STATUS: begin
                rdata_c[7:0]     = 8'(fifo_count);
                rdata_c[ST_EMPTY] = fifo_empty;
                rdata_c[ST_FULL]  = fifo_full;
                rdata_c[ST_OVF]   = ovf;
                rdata_c[ST_HIGH]  = fifo_high;
            end
            REG_CTRL: rdata_c[CTRL_EN] = en;
            default:  rdata_c = '0;
        endcase
    end

    psoc_sync_fifo #(
        .WIDTH ($bits(i2s_frame_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush_c),
        .push      (push_c),
        .push_data (frame_c),
        .pop       (pop_c),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            en        <= 1'b0;
            ovf       <= 1'b0;
            fifo_high <= 1'b0;
        end else begin
            wb_ack_o  <= acc_c;
            wb_dat_o  <= (acc_c && !wb_we_i) ? rdata_c : '0;
            fifo_high <= (fifo_count >= CNT_W'(FIFO_HIGH_LEVEL));
            if (wr_ctrl_c) begin
                en <= wb_dat_i[CTRL_EN];
                if (wb_dat_i[CTRL_OVF_CLR]) begin
                    ovf <= 1'b0;
                end
            end
            if (ovf_set_c) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psoc_i2s_rx.sv
// Directed/random bench for psoc_i2s_rx: drives I2S frames as a bit-level master and
// compares Wishbone reads and fifo_high against a frame-queue model of the receiver.
module tb_psoc_i2s_rx;
    import psoc_audio_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned HIGH  = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
    logic        fifo_high;
    logic        i2s_sclk = 1'b0;
    logic        i2s_lrclk = 1'b1;
    logic        i2s_sdata = 1'b0;

    always #5 clk = ~clk;

    psoc_i2s_rx #(
        .SAMPLE_WIDTH    (16),
        .FIFO_DEPTH      (DEPTH),
        .FIFO_HIGH_LEVEL (HIGH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_we_i   (wb_we_i),
        .wb_sel_i  (wb_sel_i),
        .wb_stb_i  (wb_stb_i),
        .wb_ack_o  (wb_ack_o),
        .fifo_high (fifo_high),
        .i2s_sclk  (i2s_sclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata)
    );

    int tests = 0;
    int fails = 0;
    int hp = 16;

    // Receiver model: expected FIFO contents and capture status
    logic [31:0] exp_q[$];
    logic [31:0] pend_f;
    bit m_en, m_ovf, synced, pend_v, in_left;
    bit cur_lr = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic model_push(input logic [31:0] f);
        if (exp_q.size() < DEPTH) exp_q.push_back(f);
        else m_ovf = 1'b1;
    endtask

    // One sclk period; a falling lrclk completes any pending frame and (re)syncs
    task automatic send_bit(input logic lr, input logic d);
        if (cur_lr && !lr) begin
            if (pend_v) model_push(pend_f);
            pend_v = 1'b0;
            synced = m_en;
        end
        cur_lr    = lr;
        i2s_sclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_sdata = d;
        repeat (hp) @(negedge clk);
        i2s_sclk = 1'b1;
        repeat (hp) @(negedge clk);
    endtask

    task automatic send_word(input logic lr, input logic [15:0] w, input int nbits, input int pad);
        if (!(in_left && !lr)) send_bit(lr, 1'($urandom));
        in_left = 1'b0;
        for (int i = 0; i < nbits; i++) send_bit(lr, w[15-i]);
        for (int i = 0; i < pad; i++) send_bit(lr, 1'($urandom));
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits, input int pad);
        send_word(1'b0, l, lbits, pad);
        send_word(1'b1, r, 16, pad);
        if (synced && lbits == 16) begin
            pend_v = 1'b1;
            pend_f = {l, r};
        end
    endtask

    task automatic send_rand_frame();
        hp = $urandom_range(2, 6);
        send_frame(16'($urandom), 16'($urandom), 16, $urandom_range(0, 2));
    endtask

    // Start the next left word so the last frame completes, then let it settle
    task automatic close_frame();
        send_bit(1'b0, 1'($urandom));
        in_left = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wb_access(input logic [1:0] reg_idx, input logic we, input logic [31:0] wdat,
                             output logic [31:0] rdat);
        int waited = 0;
        wb_adr_i = {28'h0, reg_idx, 2'b00};
        wb_we_i  = we;
        wb_dat_i = wdat;
        wb_stb_i = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!wb_ack_o && waited < 4);
        check("wb_ack_latency", 32'(waited), 32'd1);
        rdat     = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk);
        check("wb_ack_pulse", {31'b0, wb_ack_o}, 32'd0);
        check("wb_dat_idle", wb_dat_o, 32'd0);
    endtask

    task automatic set_ctrl(input logic [31:0] v);
        logic [31:0] d;
        wb_access(REG_CTRL, 1'b1, v, d);
        m_en = v[0];
        if (!v[0]) begin
            synced = 1'b0;
            pend_v = 1'b0;
        end
        if (v[1]) m_ovf = 1'b0;
        if (v[2]) exp_q.delete();
    endtask

    task automatic read_data(input string tag);
        logic [31:0] d, e;
        e = 32'h0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        wb_access(REG_DATA, 1'b0, 32'h0, d);
        check(tag, d, e);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d, e;
        int n;
        n = exp_q.size();
        e = {20'h0, (n >= HIGH), m_ovf, (n == DEPTH), (n == 0), 8'(n)};
        wb_access(REG_STATUS, 1'b0, 32'h0, d);
        check(tag, d, e);
    endtask

    task automatic check_high(input string tag);
        check(tag, {31'b0, fifo_high}, {31'b0, exp_q.size() >= HIGH});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check_high("rst_high");
        check_status("rst_status");

        // Basic capture at sclk = clk/32
        set_ctrl(32'h1);
        wb_access(REG_CTRL, 1'b0, 32'h0, d);
        check("ctrl_readback", d, 32'h1);
        repeat (3) send_bit(1'b1, 1'($urandom));
        send_frame(16'hA5C3, 16'h1234, 16, 0);
        close_frame();
        check_status("cap_status");
        read_data("cap_data");
        check_status("cap_empty");

        // Enable mid right word: capture begins at the next lrclk falling edge
        set_ctrl(32'h0);
        hp = 3;
        send_word(1'b0, 16'($urandom), 16, 0);
        send_word(1'b1, 16'($urandom), 8, 0);
        set_ctrl(32'h1);
        repeat (8) send_bit(1'b1, 1'($urandom));
        send_rand_frame();
        send_rand_frame();
        close_frame();
        check_status("sync_status");
        read_data("sync_data0");
        read_data("sync_data1");

        // Disable mid-frame: partial frame dropped, stored frame kept
        send_rand_frame();
        send_word(1'b0, 16'($urandom), 16, 0);
        send_word(1'b1, 16'($urandom), 8, 0);
        set_ctrl(32'h0);
        repeat (8) send_bit(1'b1, 1'($urandom));
        set_ctrl(32'h1);
        close_frame();
        check_status("endrop_status");
        send_rand_frame();
        close_frame();
        check_status("endrop_resume");
        read_data("endrop_data0");
        read_data("endrop_data1");

        // Overflow: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_rand_frame();
        close_frame();
        check_high("ovf_high");
        check_status("ovf_status");
        set_ctrl(32'h3);
        check_status("ovf_cleared");
        for (int i = 0; i < 16; i++) read_data("ovf_drain");
        check_status("ovf_empty");

        // Threshold on fifo_high
        for (int i = 0; i < 7; i++) send_rand_frame();
        close_frame();
        check_high("thr_7");
        send_rand_frame();
        close_frame();
        check_high("thr_8");
        check_status("thr_status");
        read_data("thr_read");
        repeat (2) @(negedge clk);
        check_high("thr_after_read");

        // Short left word spoils its frame; the next frame is captured
        hp = 4;
        send_frame(16'($urandom), 16'($urandom), 12, 0);
        send_frame(16'($urandom), 16'($urandom), 16, 0);
        close_frame();
        check_status("trunc_status");
        for (int i = 0; i < 8; i++) read_data("trunc_drain");

        // Reset in the middle of a left word with the FIFO above threshold
        for (int i = 0; i < 9; i++) send_rand_frame();
        close_frame();
        check_high("prerst_high");
        send_word(1'b0, 16'($urandom), 8, 0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        m_en = 1'b0;
        m_ovf = 1'b0;
        synced = 1'b0;
        pend_v = 1'b0;
        in_left = 1'b0;
        check("midrst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("midrst_dat", wb_dat_o, 32'd0);
        check_high("midrst_high");
        check_status("midrst_status");
        wb_access(REG_CTRL, 1'b0, 32'h0, d);
        check("midrst_ctrl", d, 32'h0);

        // Flush in the same cycle as a push
        set_ctrl(32'h1);
        hp = 4;
        repeat (3) send_bit(1'b1, 1'($urandom));
        send_rand_frame();
        close_frame();
        hp = 4;
        send_frame(16'($urandom), 16'($urandom), 16, 0);
        pend_v = 1'b0;
        cur_lr = 1'b0;
        in_left = 1'b1;
        i2s_sclk = 1'b0;
        i2s_lrclk = 1'b0;
        i2s_sdata = 1'b0;
        repeat (hp) @(negedge clk);
        i2s_sclk = 1'b1;
        repeat (2) @(negedge clk);
        set_ctrl(32'h5);
        check_status("flush_status");
        read_data("empty_read");
        send_rand_frame();
        close_frame();
        check_status("post_flush_status");
        read_data("post_flush_data");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psoc_i2s_rx.md
Name: psoc_i2s_rx

Overview:
- I2S slave receiver for the audio subsystem; the capture-direction counterpart of the psoc_audio I2S playback path.
- Oversamples externally driven i2s_sclk/i2s_lrclk/i2s_sdata in the system clock domain and deserialises left/right words.
- Buffers stereo frames in a FIFO read by the neorv32 CPU over Wishbone; raises an XIRQ-level interrupt when the FIFO reaches a threshold.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel word captured, MSB first; range 8..16.
- FIFO_DEPTH, 16, stereo frames buffered; power of two, at least 4.
- FIFO_HIGH_LEVEL, 8, fill level at or above which fifo_high asserts; range 1..FIFO_DEPTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  synchronous active-low reset.
- wb_adr_i  in  32  Wishbone address; only bits [3:2] are decoded.
- wb_dat_i  in  32  Wishbone write data.
- wb_dat_o  out  32  Wishbone read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte select; ignored, all accesses are treated as 32-bit.
- wb_stb_i  in  1  strobe, held high until ack.
- wb_ack_o  out  1  acknowledge.
- fifo_high  out  1  level interrupt: FIFO count >= FIFO_HIGH_LEVEL.
- i2s_sclk  in  1  bit clock from the external master, asynchronous to clk.
- i2s_lrclk  in  1  word select: 0 = left, 1 = right.
- i2s_sdata  in  1  serial data.

Behaviour:
- Reset (rstn low at a clk edge) clears:
  - outputs: wb_ack_o=0, wb_dat_o=0, fifo_high=0;
  - state: FIFO, CTRL.EN, overflow flag, shift register, bit counter, FSM (-> IDLE).
- Input synchronisers:
  - Two flops per I2S input; one further register on sclk/lrclk for edge detection.
  - Requirement: f_sclk <= f_clk/4.
- Sampling:
  - Synced sdata and lrclk are sampled in the cycle a rising sclk edge is detected.
  - Bit counter clears whenever the sampled lrclk differs from the previous sampled lrclk.
  - The bit with counter 0 is the I2S delay bit and is discarded.
  - Counter values 1..SAMPLE_WIDTH shift into the word MSB first; later bits are ignored, and the counter saturates.
- FSM:
  - IDLE: EN=0.
  - WAIT_SYNC: EN=1; waits for a sampled lrclk 1->0 transition.
  - LEFT -> RIGHT on a sampled lrclk 0->1, and RIGHT -> LEFT on 1->0.
  - Leaving LEFT: the left word is latched if exactly SAMPLE_WIDTH bits were received, otherwise the frame is marked bad.
  - Leaving RIGHT: the frame is pushed only if both words are complete and the frame is not bad.
  - Any return to EN=0 -> IDLE.
- Frame format:
  - {left, right}: left in [31:16], right in [15:0].
  - Each word is MSB-aligned within its half, low bits zero when SAMPLE_WIDTH < 16.
- Push latency: FIFO count increments no later than 4 clk cycles after the pad-level sclk rising edge that carries the first bit of the next left word.
- FIFO full at push: the frame is dropped and the sticky OVF is set; FIFO contents are unchanged.
- Simultaneous push and pop: the count is unchanged and both operations take effect.
- Wishbone:
  - wb_ack_o <= wb_stb_i & ~wb_ack_o, so ack is a 1-cycle pulse one cycle after stb.
  - The side effect (pop or write) occurs in the ack cycle, exactly once per access.
  - wb_dat_o is valid during ack and 0 otherwise.
- Registers (by adr[3:2]):
  - 0 DATA, R: pops the head frame. When empty, returns 0 with no pop. Writes are ignored.
  - 1 STATUS, R: [7:0] count, [8] empty, [9] full, [10] OVF, [11] fifo_high. Writes are ignored.
  - 2 CTRL, RW: [0] EN. Writing bit [1]=1 clears OVF (bit [1] reads 0). Writing bit [2]=1 flushes the FIFO (bit [2] reads 0).
  - 3: reads 0, writes ignored.
- EN 1->0 mid-frame: the partial frame is discarded, FIFO contents are kept, and the FSM returns to IDLE on the next cycle.
- EN 0->1: capture starts at the next lrclk falling edge; no partial frame is ever pushed.
- Flush has priority over a same-cycle push: the FIFO ends empty.
- fifo_high is registered and combinational-free: it tracks the count one cycle after the count changes.

Decomposition:
- psoc_audio_pkg holds register offsets (REG_DATA=0, REG_STATUS=1, REG_CTRL=2) and STATUS/CTRL bit indices, shared with firmware headers.
- One sub-module, psoc_sync_fifo: a generic width/depth synchronous FIFO with count/full/empty and a flush input.
- Synchroniser, deserialiser FSM and Wishbone decode stay in psoc_i2s_rx.

Test Plan:
- Capture: EN=1, clk 100 MHz, sclk 3.125 MHz, send L=0xA5C3 and R=0x1234 -> STATUS count=1; DATA read returns 0xA5C31234; count=0.
- Sync on enable: enable mid right-word, then send two full frames -> exactly 2 frames, the first being the first complete L/R pair after the lrclk falling edge.
- Overflow: EN=1, send 17 frames without reading -> count=16, full=1, OVF=1; 17th frame absent; CTRL write 0x2 -> OVF=0.
- Threshold: send 7 frames -> fifo_high=0; 8th frame -> fifo_high=1; one DATA read -> fifo_high=0 within 2 cycles.
- Truncation: send a left word of 12 bits, then a full right word -> nothing pushed; the following good frame is pushed normally.
- Reset and flush: rstn low mid-frame for 1 cycle -> all outputs 0, count=0. Flush during a push cycle -> count=0. DATA read when empty -> 0, ack in one cycle.
